// File: rtl/komandara_k10_pkg.sv
// Shared types for the K10 M-extension sequencer: op encoding (funct3), FSM states.
package komandara_k10_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int MD_DIV_STEPS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/k10_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module k10_div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [33:0] shifted;
  logic [33:0] diff;
  logic        fits;

  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {2'b00, divisor};
  assign fits    = ~diff[33];
  assign rem_nxt = fits ? diff[32:0] : shifted[32:0];
  assign quo_nxt = {quo[30:0], fits};

endmodule

// File: rtl/k10_md_seq.sv
// K10 M-extension sequencer: pipelined multiply, 32-step restoring divide, flush/back-to-back.
// Optional K10_MD_EARLY_OUT_EN: dividend < divisor finishes in one cycle.
module k10_md_seq
  import komandara_k10_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  md_state_e   state, state_nxt;
  md_op_e      op_q;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo, divisor;
  logic        neg_q, neg_r;
  logic [63:0] prod_pipe [MUL_LAT];

  logic        accept, is_mul, sgn, is_rem, div_zero, ovf, early, special;
  logic        sa, sb;
  logic [31:0] a_abs, b_abs, special_res, mul_res, quo_fix, rem_fix;
  logic [63:0] prod;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  assign accept   = i_valid && o_ready;
  assign is_mul   = ~i_op[2];
  assign sgn      = i_op[2] & ~i_op[0];
  assign is_rem   = i_op[1];
  assign a_abs    = abs32(i_rs1, sgn);
  assign b_abs    = abs32(i_rs2, sgn);
  assign div_zero = (i_rs2 == 32'd0);
  assign ovf      = sgn && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
`ifdef K10_MD_EARLY_OUT_EN
  assign early    = (a_abs < b_abs) && !div_zero;
`else
  assign early    = 1'b0;
`endif
  assign special  = div_zero || ovf || early;

  always_comb begin
    special_res = 32'd0;
    if (div_zero)   special_res = is_rem ? i_rs1 : 32'hFFFF_FFFF;
    else if (ovf)   special_res = is_rem ? 32'd0 : 32'h8000_0000;
    else if (early) special_res = is_rem ? i_rs1 : 32'd0;
  end

  // 33x33 signed product, computed on 64-bit extended operands (low 64 bits are exact)
  assign sa   = i_rs1[31] & (i_op != MD_MULHU);
  assign sb   = i_rs2[31] & ((i_op == MD_MUL) || (i_op == MD_MULH));
  assign prod = {{32{sa}}, i_rs1} * {{32{sb}}, i_rs2};

  assign mul_res = (op_q == MD_MUL) ? prod_pipe[MUL_LAT-1][31:0] : prod_pipe[MUL_LAT-1][63:32];

  k10_div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  assign quo_fix = neg_q ? (32'd0 - step_quo) : step_quo;
  assign rem_fix = neg_r ? (32'd0 - step_rem[31:0]) : step_rem[31:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = ((state == IDLE) || (state == DONE)) && !i_flush;
    o_busy    = (state == MUL) || (state == DIV);
    o_valid   = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (accept)              state_nxt = is_mul ? MUL : (special ? DONE : DIV);
        else if (state == DONE)  state_nxt = IDLE;
      end
      MUL, DIV: if (cnt == 5'd0) state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= MD_MUL;
      cnt      <= 5'd0;
      rem      <= 33'd0;
      quo      <= 32'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_result <= 32'd0;
      for (int k = 0; k < MUL_LAT; k++) prod_pipe[k] <= 64'd0;
    end else begin
      for (int k = 1; k < MUL_LAT; k++) prod_pipe[k] <= prod_pipe[k-1];
      if (accept) begin
        op_q    <= md_op_e'(i_op);
        cnt     <= is_mul ? 5'(MUL_LAT - 1) : 5'(MD_DIV_STEPS - 1);
        rem     <= 33'd0;
        quo     <= a_abs;
        divisor <= b_abs;
        neg_q   <= sgn & (i_rs1[31] ^ i_rs2[31]);
        neg_r   <= sgn & i_rs1[31];
        prod_pipe[0] <= prod;
        if (!is_mul && special) o_result <= special_res;
      end else if (state == MUL) begin
        if (cnt != 5'd0) cnt <= cnt - 5'd1;
        else             o_result <= mul_res;
      end else if (state == DIV) begin
        rem <= step_rem;
        quo <= step_quo;
        if (cnt != 5'd0) cnt <= cnt - 5'd1;
        else             o_result <= op_q[1] ? rem_fix : quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_k10_md_seq.sv
// Directed self-checking bench for k10_md_seq (MUL_LAT=2); honours K10_MD_EARLY_OUT_EN.
module tb_k10_md_seq;

  localparam int MUL_LAT = 2;
`ifdef K10_MD_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk, rst_n, valid, ready, flush, busy, res_valid;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;
  int total = 0;
  int bad = 0;

  k10_md_seq #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_op(op),
    .i_rs1(rs1), .i_rs2(rs2), .i_flush(flush), .o_busy(busy), .o_valid(res_valid),
    .o_result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  // lat = cycle offset from accept at which o_valid is seen, -1 if never within budget
  task automatic wait_valid(output int lat, output int busy_n, output logic [31:0] res);
    lat = -1; busy_n = 0; res = 32'd0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (res_valid) begin lat = k; res = result; break; end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat, bn;
    logic [31:0] r;
    @(negedge clk);
    issue(o, a, b);
    wait_valid(lat, bn, r);
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
    total++;
    if (r !== exp_res) begin bad++; $display("FAIL %s result got %h want %h", name, r, exp_res); end
  endtask

  task automatic test_reset;
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", ready); end
  endtask

  task automatic test_mul;
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, MUL_LAT + 1, 32'hFFFF_FFEB);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT + 1, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,        MUL_LAT + 1, 32'hFFFF_FFFF);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, MUL_LAT + 1, 32'h4000_0000);
  endtask

  task automatic test_div;
    int lat, bn;
    logic [31:0] r;
    @(negedge clk);
    issue(3'd4, 32'd100, 32'hFFFF_FFF9);
    wait_valid(lat, bn, r);
    total++; if (lat !== 33) begin bad++; $display("FAIL div_lat got %0d want 33", lat); end
    total++; if (bn !== 32) begin bad++; $display("FAIL div_busy_cycles got %0d want 32", bn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL div_busy_in_done got %b want 0", busy); end
    total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL div_res got %h want fffffff2", r); end
    run_op("rem_pos_neg", 3'd6, 32'd100,        32'hFFFF_FFF9, 33, 32'd2);
    run_op("div_neg_pos", 3'd4, 32'hFFFF_FF9C,  32'd7,        33, 32'hFFFF_FFF2);
    run_op("rem_neg_pos", 3'd6, 32'hFFFF_FF9C,  32'd7,        33, 32'hFFFF_FFFE);
    run_op("divu_big",    3'd5, 32'hFFFF_FFFF,  32'd7,        33, 32'h2492_4924);
    run_op("remu_big",    3'd7, 32'hFFFF_FFFF,  32'd7,        33, 32'd3);
  endtask

  task automatic test_special;
    run_op("divu_by0", 3'd5, 32'd5,         32'd0,         1, 32'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5,         32'd0,         1, 32'd5);
    run_op("div_by0",  3'd4, 32'hFFFF_FFFB, 32'd0,         1, 32'hFFFF_FFFF);
    run_op("rem_by0",  3'd6, 32'hFFFF_FFFB, 32'd0,         1, 32'hFFFF_FFFB);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
  endtask

  task automatic test_early;
    run_op("divu_small", 3'd5, 32'd3,         32'd10, EARLY_LAT, 32'd0);
    run_op("rem_small",  3'd6, 32'hFFFF_FFFD, 32'd10, EARLY_LAT, 32'hFFFF_FFFD);
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    issue(3'd5, 32'd10, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_ready_n10 got %b want 0", ready); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready_n11 got %b want 1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_n11 got %b want 0", busy); end
    seen = 0;
    repeat (40) begin if (res_valid) seen++; @(negedge clk); end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_valid got %0d strobes want 0", seen); end
    // flush coinciding with a request: nothing is accepted
    valid = 1'b1; op = 3'd0; rs1 = 32'd2; rs2 = 32'd3; flush = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_accept_ready got %b want 0", ready); end
    @(posedge clk); #1; valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (res_valid || busy) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_accept_idle got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    logic [31:0] r;
    @(negedge clk);
    issue(3'd5, 32'd10, 32'd3);
    wait_valid(lat, bn, r);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL b2b_div_res got %h want 3", r); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_done_ready got %b want 1", ready); end
    issue(3'd0, 32'd6, 32'd7);
    wait_valid(lat, bn, r);
    total++; if (lat !== MUL_LAT + 1) begin bad++; $display("FAIL b2b_mul_lat got %0d want %0d", lat, MUL_LAT + 1); end
    total++; if (r !== 32'd42) begin bad++; $display("FAIL b2b_mul_res got %h want 2a", r); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL midrst_result got %h want 0", result); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", res_valid); end
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst_mul", 3'd0, 32'd3, 32'd4, MUL_LAT + 1, 32'd12);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_early();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
